// File: rtl/csa_accumulator.sv
// rtl/csa_accumulator.sv - carry-save packet accumulator with single-cycle resolve
//
// Purpose:
//   Accumulates a packet of signed operands in carry-save form (one CSA level
//   per operand, no carry propagation on the accumulate path). After the last
//   operand, one RESOLVE cycle performs a single carry-propagate add, then the
//   result is held in OUT until the consumer takes it.
//
// Optional feature:
//   CSA_ACC_OVF_EN - when defined, adds port out_ovf, flagging a resolved sum
//   that does not fit in signed WIDTH bits.
//
// Ports:
//   clk        input   1      rising-edge clock
//   rst_n      input   1      asynchronous active-low reset
//   in_valid   input   1      operand present
//   in_ready   output  1      operand accepted this cycle (ACC state only)
//   in_data    input   WIDTH  signed operand
//   in_sub     input   1      0: add, 1: subtract operand
//   in_last    input   1      final operand of the packet
//   out_valid  output  1      result present (OUT state)
//   out_ready  input   1      consumer takes the result
//   out_data   output  AW     resolved signed packet sum, AW = WIDTH+GUARD
//   out_cnt    output  8      operand count, saturating at 255
//   out_ovf    output  1      result outside signed WIDTH range (macro only)

module csa_accumulator #(
  parameter int WIDTH = 16,
  parameter int GUARD = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_sub,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH+GUARD-1:0]   out_data,
`ifdef CSA_ACC_OVF_EN
  output logic [7:0]               out_cnt,
  output logic                     out_ovf
`else
  output logic [7:0]               out_cnt
`endif
);

  localparam int AW = WIDTH + GUARD;

  typedef enum logic [1:0] {
    ST_ACC     = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_OUT     = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [AW-1:0] sum_reg;
  logic [AW-1:0] carry_reg;
  logic [AW-1:0] operand_x;
  logic [AW-1:0] sum_next;
  logic [AW-2:0] maj_lo;
  logic [AW-1:0] carry_next;
  logic [AW-1:0] resolved;
  logic          accept;
  logic          release_out;

  // Operand path: sign-extend, then one's complement for subtraction; the
  // missing +1 enters through carry bit 0, which a left-shifted majority
  // vector never occupies.
  always_comb begin
    operand_x  = {{GUARD{in_data[WIDTH-1]}}, in_data} ^ {AW{in_sub}};
    sum_next   = sum_reg ^ operand_x ^ carry_reg;
    // Only the low AW-1 majority bits survive the shift; the top one is the
    // modulo-2^AW discard.
    maj_lo     = (sum_reg[AW-2:0] & operand_x[AW-2:0])
               | (sum_reg[AW-2:0] & carry_reg[AW-2:0])
               | (operand_x[AW-2:0] & carry_reg[AW-2:0]);
    carry_next = {maj_lo, in_sub};
    resolved   = sum_reg + carry_reg;
  end

  always_comb begin
    in_ready    = (state == ST_ACC);
    out_valid   = (state == ST_OUT);
    accept      = in_valid && (state == ST_ACC);
    release_out = out_ready && (state == ST_OUT);
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_ACC: begin
        if (accept && in_last) begin
          state_next = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        state_next = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          state_next = ST_ACC;
        end
      end
      default: begin
        state_next = ST_ACC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ACC;
    end else begin
      state <= state_next;
    end
  end

  // Carry-save state and operand counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg   <= '0;
      carry_reg <= '0;
      out_cnt   <= 8'd0;
    end else if (release_out) begin
      sum_reg   <= '0;
      carry_reg <= '0;
      out_cnt   <= 8'd0;
    end else if (accept) begin
      sum_reg   <= sum_next;
      carry_reg <= carry_next;
      if (out_cnt != 8'hFF) begin
        out_cnt <= out_cnt + 8'd1;
      end
    end
  end

  // Result register: loaded once in RESOLVE, held through OUT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
    end else if (release_out) begin
      out_data <= '0;
    end else if (state == ST_RESOLVE) begin
      out_data <= resolved;
    end
  end

`ifdef CSA_ACC_OVF_EN
  // The sum fits signed WIDTH bits only when the guard bits and the WIDTH
  // sign bit are all copies of one another.
  logic ovf_calc;

  always_comb begin
    ovf_calc = !((&resolved[AW-1:WIDTH-1]) || (~|resolved[AW-1:WIDTH-1]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_ovf <= 1'b0;
    end else if (release_out) begin
      out_ovf <= 1'b0;
    end else if (state == ST_RESOLVE) begin
      out_ovf <= ovf_calc;
    end
  end
`endif

endmodule

// File: tb/tb_csa_accumulator.sv
// tb/tb_csa_accumulator.sv - self-checking bench for csa_accumulator

module tb_csa_accumulator;

  localparam int WIDTH = 8;
  localparam int GUARD = 4;
  localparam int AW    = WIDTH + GUARD;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          in_sub;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic [7:0]    out_cnt;
  logic          ovf_w;

  int checks;
  int errors;

  csa_accumulator #(.WIDTH(WIDTH), .GUARD(GUARD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sub    (in_sub),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef CSA_ACC_OVF_EN
    .out_cnt   (out_cnt),
    .out_ovf   (ovf_w)
`else
    .out_cnt   (out_cnt)
`endif
  );

`ifndef CSA_ACC_OVF_EN
  assign ovf_w = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer sum of the signed operands
  int model_acc;
  int model_cnt;

  function automatic logic [AW-1:0] model_data(input int acc);
    return AW'(acc);
  endfunction

  function automatic logic model_ovf(input int acc);
    int v;
    v = acc % 4096;
    if (v < 0) v += 4096;
    if (v > 2047) v -= 4096;
    return (v > 127) || (v < -128);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one operand and hold it until accepted (bounded).
  task automatic send(input logic [7:0] d, input logic s, input logic l);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sub   = s;
    in_last  = l;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      chk("send_timeout", 32'd1, 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    model_acc = s ? model_acc - int'($signed(d)) : model_acc + int'($signed(d));
    if (model_cnt < 255) model_cnt++;
  endtask

  // Wait for the result, compare, then take it with out_ready.
  task automatic collect(input string name, input logic [AW-1:0] exp_data,
                         input int exp_cnt, input logic exp_ovf);
    int guard;
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_data"}, 32'(out_data), 32'(exp_data));
    chk({name, "_cnt"}, 32'(out_cnt), 32'(exp_cnt));
`ifdef CSA_ACC_OVF_EN
    chk({name, "_ovf"}, 32'(ovf_w), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) chk({name, "_ovf"}, 32'(ovf_w), 32'd0);
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, "_released"}, 32'(out_valid), 32'd0);
    chk({name, "_ready_again"}, 32'(in_ready), 32'd1);
    model_acc = 0;
    model_cnt = 0;
  endtask

  typedef struct {
    string           name;
    int              n;
    logic [2:0][7:0] d;
    logic [2:0]      s;
    logic [AW-1:0]   exp_data;
    int              exp_cnt;
    logic            exp_ovf;
  } vec_t;

  vec_t vecs[6];

  initial begin
    checks    = 0;
    errors    = 0;
    model_acc = 0;
    model_cnt = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    in_sub    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    vecs[0] = '{"add3",    3, {8'd7, 8'd3, 8'd5},       3'b000, 12'h00F, 3, 1'b0};
    vecs[1] = '{"addsub",  2, {8'd0, 8'd3, 8'd10},      3'b010, 12'h007, 2, 1'b0};
    vecs[2] = '{"neg128",  1, {8'd0, 8'd0, 8'h80},      3'b001, 12'h080, 1, 1'b1};
    vecs[3] = '{"minus2",  2, {8'd0, 8'hFF, 8'hFF},     3'b000, 12'hFFE, 2, 1'b0};
    vecs[4] = '{"sub128",  2, {8'd0, 8'd1, 8'd127},     3'b011, 12'hF80, 2, 1'b0};
    vecs[5] = '{"m256",    2, {8'd0, 8'h80, 8'h80},     3'b000, 12'hF00, 2, 1'b1};

    #12;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_data", 32'(out_data), 32'd0);
    chk("reset_cnt", 32'(out_cnt), 32'd0);
    chk("reset_ovf", 32'(ovf_w), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_ready", 32'(in_ready), 32'd1);

    // Table vectors, with the two-edge latency checked on every last operand
    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        send(vecs[i].d[k], vecs[i].s[k], k == vecs[i].n - 1);
      end
      chk({vecs[i].name, "_resolve_not_valid"}, 32'(out_valid), 32'd0);
      chk({vecs[i].name, "_resolve_not_ready"}, 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      chk({vecs[i].name, "_latency"}, 32'(out_valid), 32'd1);
      collect(vecs[i].name, vecs[i].exp_data, vecs[i].exp_cnt, vecs[i].exp_ovf);
    end

    // 16 and 17 operands of +127: guard bits absorb, then wrap
    for (int k = 0; k < 16; k++) send(8'd127, 1'b0, k == 15);
    collect("x16", 12'h7F0, 16, 1'b1);
    for (int k = 0; k < 17; k++) send(8'd127, 1'b0, k == 16);
    collect("x17", 12'h86F, 17, 1'b1);

    // Back-pressure in OUT: pending operand must not be absorbed
    send(8'd20, 1'b0, 1'b0);
    send(8'd22, 1'b0, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 8'd50;
    in_last  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("stall_ready", 32'(in_ready), 32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'd42);
      chk("stall_cnt", 32'(out_cnt), 32'd2);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    collect("stall", 12'd42, 2, 1'b0);
    send(8'd1, 1'b0, 1'b1);
    collect("after_stall", 12'h001, 1, 1'b0);

    // Reset mid-packet discards the partial sum
    send(8'd9, 1'b0, 1'b0);
    send(8'd9, 1'b0, 1'b0);
    chk("pre_reset_cnt", 32'(out_cnt), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_cnt", 32'(out_cnt), 32'd0);
    chk("midrst_data", 32'(out_data), 32'd0);
    chk("midrst_ovf", 32'(ovf_w), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b1;
    model_acc = 0;
    model_cnt = 0;
    @(posedge clk); #1;
    send(8'd1, 1'b0, 1'b1);
    collect("post_reset", 12'h001, 1, 1'b0);

    // Counter saturation with a 300-operand packet
    for (int k = 0; k < 300; k++) begin
      send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), k == 299);
    end
    collect("saturate", model_data(model_acc), 255, model_ovf(model_acc));

    // Randomized packets with idle gaps and consumer delay
    for (int p = 0; p < 40; p++) begin
      int n;
      int dly;
      n = $urandom_range(1, 12);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
        send(8'($urandom), 1'($urandom_range(0, 1)), k == n - 1);
      end
      dly = $urandom_range(0, 4);
      for (int k = 0; k < dly; k++) begin
        @(posedge clk); #1;
      end
      collect("random", model_data(model_acc), model_cnt, model_ovf(model_acc));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
